// File: rtl/mod_counter.sv
// Up/down modulo counter with optional prescaler, wrap or saturate at the bounds,
// registered overflow/underflow pulses and a combinational terminal-count flag.
module mod_counter #(
  parameter int DATA_WIDTH = 5,
  parameter int MODULUS    = 2**DATA_WIDTH,
  parameter int PRESCALE   = 1,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  ovf,
  output logic                  unf,
  output logic                  tc
);

  localparam int EW = DATA_WIDTH + 1;
  localparam logic [EW-1:0]         TOP_EXT = EW'(MODULUS - 1);
  localparam logic [EW-1:0]         MOD_EXT = EW'(MODULUS);
  localparam logic [DATA_WIDTH-1:0] TOP     = DATA_WIDTH'(MODULUS - 1);

  logic [EW-1:0]         count_ext;
  logic [EW-1:0]         load_ext;
  logic [EW-1:0]         step_up;
  logic [EW-1:0]         step_dn;
  logic                  tick;
  logic [DATA_WIDTH-1:0] count_nxt;
  logic                  ovf_nxt;
  logic                  unf_nxt;

  // One extra bit lets MODULUS = 2**DATA_WIDTH be detected as a carry and 0-1 as a borrow.
  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_val};
  assign step_up   = count_ext + EW'(1);
  assign step_dn   = count_ext - EW'(1);

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre;

      assign tick = en && (pre == PRE_LAST);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pre <= '0;
        end else if (load) begin
          pre <= '0;
        end else if (en) begin
          pre <= tick ? '0 : pre + PW'(1);
        end
      end
    end else begin : g_nopre
      assign tick = en;
    end
  endgenerate

  always_comb begin
    count_nxt = count;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (load) begin
      count_nxt = (load_ext > TOP_EXT) ? TOP : load_val;
    end else if (tick) begin
      if (up) begin
        if (step_up == MOD_EXT) begin
          ovf_nxt = 1'b1;
          if (SATURATE == 0) begin
            count_nxt = '0;
          end
        end else begin
          count_nxt = step_up[DATA_WIDTH-1:0];
        end
      end else begin
        if (step_dn[EW-1]) begin
          unf_nxt = 1'b1;
          if (SATURATE == 0) begin
            count_nxt = TOP;
          end
        end else begin
          count_nxt = step_dn[DATA_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end

  assign tc = up ? (count == TOP) : (count == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Drives three differently configured counters from shared random inputs and
// compares each against a cycle-level reference model of the counting rules.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = '0;

  logic [4:0] dut_count [3];
  logic [2:0] dut_ovf;
  logic [2:0] dut_unf;
  logic [2:0] dut_tc;

  int checks = 0;
  int errors = 0;

  int cfg_mod [3] = '{32, 20, 20};
  int cfg_pre [3] = '{1, 3, 1};
  int cfg_sat [3] = '{0, 0, 1};

  int m_cnt [3];
  int m_pre [3];
  int m_ovf [3];
  int m_unf [3];

  always #5 clk = ~clk;

  mod_counter #(.DATA_WIDTH(5)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(dut_count[0]), .ovf(dut_ovf[0]), .unf(dut_unf[0]), .tc(dut_tc[0])
  );

  mod_counter #(.DATA_WIDTH(5), .MODULUS(20), .PRESCALE(3), .SATURATE(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(dut_count[1]), .ovf(dut_ovf[1]), .unf(dut_unf[1]), .tc(dut_tc[1])
  );

  mod_counter #(.DATA_WIDTH(5), .MODULUS(20), .PRESCALE(1), .SATURATE(1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(dut_count[2]), .ovf(dut_ovf[2]), .unf(dut_unf[2]), .tc(dut_tc[2])
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_pre[i] = 0;
      m_ovf[i] = 0;
      m_unf[i] = 0;
    end
  endtask

  // Next state of every configuration for the inputs currently applied.
  task automatic modelEdge();
    for (int i = 0; i < 3; i++) begin
      m_ovf[i] = 0;
      m_unf[i] = 0;
      if (load) begin
        m_cnt[i] = (int'(load_val) >= cfg_mod[i]) ? cfg_mod[i] - 1 : int'(load_val);
        m_pre[i] = 0;
      end else if (en) begin
        if (m_pre[i] == cfg_pre[i] - 1) begin
          m_pre[i] = 0;
          if (up) begin
            if (m_cnt[i] == cfg_mod[i] - 1) begin
              m_ovf[i] = 1;
              if (cfg_sat[i] == 0) m_cnt[i] = (m_cnt[i] + 1) % cfg_mod[i];
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end else begin
            if (m_cnt[i] == 0) begin
              m_unf[i] = 1;
              if (cfg_sat[i] == 0) m_cnt[i] = cfg_mod[i] - 1;
            end else begin
              m_cnt[i] = m_cnt[i] - 1;
            end
          end
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
      end
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 3; i++) begin
      int exp_tc;
      exp_tc = up ? int'(m_cnt[i] == cfg_mod[i] - 1) : int'(m_cnt[i] == 0);
      checkOutput($sformatf("cfg%0d count", i), int'(dut_count[i]), m_cnt[i]);
      checkOutput($sformatf("cfg%0d ovf", i), int'(dut_ovf[i]), m_ovf[i]);
      checkOutput($sformatf("cfg%0d unf", i), int'(dut_unf[i]), m_unf[i]);
      checkOutput($sformatf("cfg%0d tc", i), int'(dut_tc[i]), exp_tc);
      checkOutput($sformatf("cfg%0d ovf&unf", i), int'(dut_ovf[i] & dut_unf[i]), 0);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit u, input bit l, input int lv);
    en       = e;
    up       = u;
    load     = l;
    load_val = 5'(lv);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic asyncReset();
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    reset = 1'b1;

    repeat (33) applyStimulus(1'b1, 1'b1, 1'b0, 0);

    asyncReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0);

    applyStimulus(1'b0, 1'b1, 1'b1, 18);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 0);

    asyncReset();
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 0);

    applyStimulus(1'b1, 1'b1, 1'b1, 25);
    applyStimulus(1'b1, 1'b1, 1'b1, 31);
    applyStimulus(1'b1, 1'b1, 1'b0, 0);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(99) == 0) begin
        asyncReset();
      end else begin
        applyStimulus($urandom_range(3) != 0, 1'($urandom_range(1)),
                      $urandom_range(19) == 0, int'($urandom_range(31)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 5, the count register width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 2**DATA_WIDTH, the count range 0..MODULUS-1; legal range 2..2**DATA_WIDTH.
REQ-003 The block SHALL have parameter PRESCALE, default 1, the number of enabled cycles per count step; legal range 1..65535.
REQ-004 The block SHALL have parameter SATURATE, default 0: 0 selects wrap-around, 1 selects hold-at-bound.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-007 The block SHALL have port en, input, 1 bit: count enable.
REQ-008 The block SHALL have port up, input, 1 bit: direction (1 = increment, 0 = decrement).
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 The block SHALL have port load_val, input, DATA_WIDTH bits: value to load.
REQ-011 The block SHALL have port count, output, DATA_WIDTH bits: registered current count.
REQ-012 The block SHALL have port ovf, output, 1 bit: registered one-cycle pulse on an up-step past MODULUS-1.
REQ-013 The block SHALL have port unf, output, 1 bit: registered one-cycle pulse on a down-step past 0.
REQ-014 The block SHALL have port tc, output, 1 bit: combinational terminal count; 1 when count==MODULUS-1 with up=1, or count==0 with up=0.

Function
REQ-015 An internal prescaler pre SHALL hold 0..PRESCALE-1; a step tick SHALL occur on an edge with en=1 and pre==PRESCALE-1.
REQ-016 With en=1 and no tick, pre SHALL increment; on a tick pre SHALL return to 0; with en=0, pre and count SHALL hold.
REQ-017 PRESCALE=1 SHALL give a tick on every edge with en=1 and no prescaler register SHALL affect timing.
REQ-018 On a tick with up=1 and count<MODULUS-1, count SHALL become count+1, ovf=0.
REQ-019 On a tick with up=1 and count==MODULUS-1: SATURATE=0 -> count=0, ovf=1; SATURATE=1 -> count holds, ovf=1.
REQ-020 On a tick with up=0 and count>0, count SHALL become count-1, unf=0.
REQ-021 On a tick with up=0 and count==0: SATURATE=0 -> count=MODULUS-1, unf=1; SATURATE=1 -> count holds, unf=1.
REQ-022 ovf and unf SHALL be 0 on every edge without a qualifying bound step; they SHALL never be 1 together.
REQ-023 load=1 SHALL take priority over en: count=load_val (clamped to MODULUS-1 if load_val>=MODULUS), pre=0, ovf=0, unf=0.
REQ-024 The step latency SHALL be one clock: count, ovf, unf reflect a tick on the edge at which it occurs.
REQ-025 Arithmetic SHALL be performed at DATA_WIDTH+1 bits internally so MODULUS=2**DATA_WIDTH wraps correctly without truncation artefacts.
REQ-026 A change of up between ticks SHALL take effect on the next tick only; pre SHALL not reset on direction change.

Reset
REQ-027 While reset=0, count=0, pre=0, ovf=0, unf=0, asynchronously, regardless of clk, en, load.
REQ-028 Reset asserted mid-prescale SHALL discard partial progress; the first tick after release SHALL occur PRESCALE enabled edges after release.
REQ-029 Deassertion SHALL take effect for the next rising clk edge; no step SHALL occur on an edge where reset=0.

Verification
REQ-030 Defaults, DATA_WIDTH=5: reset, en=1 up=1 for 32 edges -> count 0..31 then 0, ovf=1 exactly on the edge 31->0.
REQ-031 MODULUS=20, up=0 from reset: first edge -> count=19, unf=1; next edge -> 18, unf=0; tc=1 while count=0 with up=0.
REQ-032 MODULUS=20 SATURATE=1: load 18, up=1, 3 edges -> 19, 19 (ovf=1), 19 (ovf=1); up=0 from load 0 -> holds 0, unf=1.
REQ-033 PRESCALE=3: en=1 up=1 from reset -> count 1 after edge 3, 2 after edge 6; en=0 for 5 edges mid-way -> count and phase frozen.
REQ-034 load=1 en=1 load_val=25 with MODULUS=20 -> count=19, ovf=0; reset=0 pulse mid-stream between edges -> count=0 immediately.
